// File: rtl/ex_mem_muldiv.sv
// EX/MEM pipeline register with an iterative 32-cycle multiply/divide unit and HI/LO registers.
// Interlocks upstream only when a HI/LO or mult/div instruction arrives while the unit is busy.
module ex_mem_muldiv #(
  parameter int unsigned len_data    = 32,
  parameter int unsigned num_bits    = 5,
  parameter int unsigned len_mem_bus = 9,
  parameter int unsigned len_wb_bus  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [len_data-1:0]    in_alu_result,
  input  logic                   in_zero_flag,
  input  logic [len_data-1:0]    in_write_data,
  input  logic [len_data-1:0]    in_rs_data,
  input  logic [len_data-1:0]    in_rt_data,
  input  logic [2:0]             in_md_op,
  input  logic [len_mem_bus-1:0] in_memory_bus,
  input  logic [len_wb_bus-1:0]  in_writeBack_bus,
  input  logic [num_bits-1:0]    in_write_reg,
  input  logic [len_data-1:0]    in_pc_branch,
  input  logic                   in_halt_flag,
  output logic [len_data-1:0]    out_addr_mem,
  output logic [len_data-1:0]    out_write_data,
  output logic [len_data-1:0]    out_pc_branch,
  output logic [len_mem_bus-1:0] out_memory_bus,
  output logic [len_wb_bus-1:0]  out_writeBack_bus,
  output logic [num_bits-1:0]    out_write_reg,
  output logic                   out_zero_flag,
  output logic                   out_halt_flag_m,
  output logic                   out_stall,
  output logic [len_data-1:0]    out_hi,
  output logic [len_data-1:0]    out_lo
);

  localparam int unsigned W    = len_data;
  localparam int unsigned CntW = $clog2(len_data);
  localparam logic [CntW-1:0] CntLast = CntW'(len_data - 1);

  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpDivu  = 3'b100;
  localparam logic [2:0] OpMfhi  = 3'b101;
  localparam logic [2:0] OpMflo  = 3'b110;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    opb_q, opb_d;
  logic            is_div_q, is_div_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            div0_q, div0_d;
  logic [W-1:0]    rs_raw_q, rs_raw_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;

  logic            busy, start_op, md_use, start, signed_op, div_op;
  logic            rs_neg, rt_neg;
  logic [W-1:0]    mag_rs, mag_rt;
  logic [W:0]      mul_sum, rem_sh, rem_diff;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quo_fix, rem_fix;

  assign busy      = (state_q != StIdle);
  assign start_op  = in_md_op inside {OpMult, OpMultu, OpDiv, OpDivu};
  assign md_use    = start_op || (in_md_op == OpMfhi) || (in_md_op == OpMflo);
  assign out_stall = busy && md_use;
  assign start     = !busy && start_op;

  assign signed_op = (in_md_op == OpMult) || (in_md_op == OpDiv);
  assign div_op    = (in_md_op == OpDiv) || (in_md_op == OpDivu);
  assign rs_neg    = signed_op && in_rs_data[W-1];
  assign rt_neg    = signed_op && in_rt_data[W-1];
  assign mag_rs    = rs_neg ? -in_rs_data : in_rs_data;
  assign mag_rt    = rt_neg ? -in_rt_data : in_rt_data;

  // Multiply: upper half accumulates, lower half holds the multiplier shifting out LSB first.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  // Divide: upper half is the partial remainder, lower half the dividend turning into quotient.
  assign rem_sh   = acc_q[2*W-1:W-1];
  assign rem_diff = rem_sh - {1'b0, opb_q};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    rs_raw_d  = rs_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          is_div_d  = div_op;
          acc_d     = {{W{1'b0}}, (div_op ? mag_rs : mag_rt)};
          opb_d     = div_op ? mag_rt : mag_rs;
          neg_res_d = rs_neg ^ rt_neg;
          neg_rem_d = rs_neg;
          div0_d    = div_op && (in_rt_data == '0);
          rs_raw_d  = in_rs_data;
          cnt_d     = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (is_div_q) begin
          if (rem_sh >= {1'b0, opb_q}) acc_d = {rem_diff[W-1:0], acc_q[W-2:0], 1'b1};
          else                         acc_d = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end else if (div0_q) begin
          hi_d = rs_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      rs_raw_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      rs_raw_q  <= rs_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Stall edges insert a bubble; datapath copies simply hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_addr_mem      <= '0;
      out_write_data    <= '0;
      out_pc_branch     <= '0;
      out_memory_bus    <= '0;
      out_writeBack_bus <= '0;
      out_write_reg     <= '0;
      out_zero_flag     <= 1'b0;
      out_halt_flag_m   <= 1'b0;
    end else if (out_stall) begin
      out_memory_bus    <= '0;
      out_writeBack_bus <= '0;
      out_write_reg     <= '0;
      out_halt_flag_m   <= 1'b0;
    end else begin
      out_addr_mem      <= (in_md_op == OpMfhi) ? hi_q :
                           (in_md_op == OpMflo) ? lo_q : in_alu_result;
      out_write_data    <= in_write_data;
      out_pc_branch     <= in_pc_branch;
      out_memory_bus    <= in_memory_bus;
      out_writeBack_bus <= in_writeBack_bus;
      out_write_reg     <= in_write_reg;
      out_zero_flag     <= in_zero_flag;
      out_halt_flag_m   <= in_halt_flag;
    end
  end

  assign out_hi = hi_q;
  assign out_lo = lo_q;

endmodule

// File: tb/tb_ex_mem_muldiv.sv
// Self-checking bench for ex_mem_muldiv: table vectors, directed interlock/reset sequences,
// and randomized mult/div checked against a plain-arithmetic reference.
module tb_ex_mem_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_alu_result, in_write_data, in_rs_data, in_rt_data, in_pc_branch;
  logic        in_zero_flag, in_halt_flag;
  logic [2:0]  in_md_op;
  logic [8:0]  in_memory_bus;
  logic [1:0]  in_writeBack_bus;
  logic [4:0]  in_write_reg;
  logic [31:0] out_addr_mem, out_write_data, out_pc_branch, out_hi, out_lo;
  logic [8:0]  out_memory_bus;
  logic [1:0]  out_writeBack_bus;
  logic [4:0]  out_write_reg;
  logic        out_zero_flag, out_halt_flag_m, out_stall;

  int checks = 0;
  int errors = 0;

  ex_mem_muldiv dut (
    .clk              (clk),
    .reset            (reset),
    .in_alu_result    (in_alu_result),
    .in_zero_flag     (in_zero_flag),
    .in_write_data    (in_write_data),
    .in_rs_data       (in_rs_data),
    .in_rt_data       (in_rt_data),
    .in_md_op         (in_md_op),
    .in_memory_bus    (in_memory_bus),
    .in_writeBack_bus (in_writeBack_bus),
    .in_write_reg     (in_write_reg),
    .in_pc_branch     (in_pc_branch),
    .in_halt_flag     (in_halt_flag),
    .out_addr_mem     (out_addr_mem),
    .out_write_data   (out_write_data),
    .out_pc_branch    (out_pc_branch),
    .out_memory_bus   (out_memory_bus),
    .out_writeBack_bus(out_writeBack_bus),
    .out_write_reg    (out_write_reg),
    .out_zero_flag    (out_zero_flag),
    .out_halt_flag_m  (out_halt_flag_m),
    .out_stall        (out_stall),
    .out_hi           (out_hi),
    .out_lo           (out_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_alu_result = '0; in_write_data = '0; in_rs_data = '0; in_rt_data = '0;
    in_pc_branch = '0; in_zero_flag = 1'b0; in_halt_flag = 1'b0; in_md_op = 3'b000;
    in_memory_bus = '0; in_writeBack_bus = '0; in_write_reg = '0;
  endtask

  // Present a start op; it is accepted at the next edge when the unit is idle.
  task automatic start_md(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    clear_inputs();
    in_md_op = op; in_rs_data = rs; in_rt_data = rt;
    tick();
    clear_inputs();
  endtask

  // Count stall cycles (bounded), also counting stall edges that failed to insert a bubble.
  task automatic count_stalls(output int n, output int bad);
    n = 0; bad = 0;
    while (out_stall && n < 60) begin
      n++;
      tick();
      if (out_writeBack_bus != 0 || out_write_reg != 0 || out_memory_bus != 0 ||
          out_halt_flag_m != 0) bad++;
    end
  endtask

  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb;
    int     ia, ib;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = int'(a);
    ib = int'(b);
    r  = '0;
    case (op)
      3'b001: r = 64'(sa * sb);
      3'b010: r = {32'h0, a} * {32'h0, b};
      3'b011: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else r = {32'(ia % ib), 32'(ia / ib)};
      end
      3'b100: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  initial begin
    int n, bad;
    logic [2:0]  op;
    logic [31:0] rs, rt;

    vt[0] = '{3'b001, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vt[1] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vt[2] = '{3'b011, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3] = '{3'b100, 32'h8000_0000, 32'd0,         32'h8000_0000, 32'hFFFF_FFFF};
    vt[4] = '{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};

    clear_inputs();
    reset = 1'b0;
    repeat (3) tick();
    chk("reset_addr", out_addr_mem, 0);
    chk("reset_wb", out_writeBack_bus, 0);
    chk("reset_hi", out_hi, 0);
    chk("reset_lo", out_lo, 0);
    chk("reset_stall", out_stall, 0);
    reset = 1'b1;
    tick();

    // Pass-through
    in_alu_result = 32'h40; in_memory_bus = 9'h002; in_writeBack_bus = 2'b11;
    in_write_reg = 5'd5; in_pc_branch = 32'h100; in_zero_flag = 1'b1;
    in_write_data = 32'hCAFE_0001;
    #1 chk("pt_stall", out_stall, 0);
    tick();
    chk("pt_addr", out_addr_mem, 32'h40);
    chk("pt_mem", out_memory_bus, 9'h002);
    chk("pt_wb", out_writeBack_bus, 2'b11);
    chk("pt_reg", out_write_reg, 5'd5);
    chk("pt_pc", out_pc_branch, 32'h100);
    chk("pt_zero", out_zero_flag, 1);
    chk("pt_wdata", out_write_data, 32'hCAFE_0001);

    // Table vectors, each read back through MFHI/MFLO as well
    for (int i = 0; i < 5; i++) begin
      start_md(vt[i].op, vt[i].rs, vt[i].rt);
      repeat (34) tick();
      chk($sformatf("tbl%0d_hi", i), out_hi, vt[i].hi);
      chk($sformatf("tbl%0d_lo", i), out_lo, vt[i].lo);
      in_md_op = 3'b101;
      tick();
      chk($sformatf("tbl%0d_mfhi", i), out_addr_mem, vt[i].hi);
      in_md_op = 3'b110;
      tick();
      chk($sformatf("tbl%0d_mflo", i), out_addr_mem, vt[i].lo);
      clear_inputs();
    end

    // MULT then dependent MFLO: 33 stall cycles of bubbles
    start_md(3'b001, 32'd7, 32'hFFFF_FFFD);
    in_md_op = 3'b110; in_write_reg = 5'd2; in_writeBack_bus = 2'b11;
    #1 count_stalls(n, bad);
    chk("mflo_stall_cycles", n, 33);
    chk("mflo_bubbles", bad, 0);
    tick();
    chk("mflo_addr", out_addr_mem, 32'hFFFF_FFEB);
    chk("mflo_reg", out_write_reg, 5'd2);
    chk("mflo_wb", out_writeBack_bus, 2'b11);
    chk("mflo_hi", out_hi, 32'hFFFF_FFFF);
    clear_inputs();

    // MULTU then independent ADD: no stall
    start_md(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    in_alu_result = 32'h1234; in_writeBack_bus = 2'b01; in_write_reg = 5'd9;
    #1 chk("add_nostall", out_stall, 0);
    tick();
    chk("add_addr", out_addr_mem, 32'h1234);
    chk("add_reg", out_write_reg, 5'd9);
    clear_inputs();
    repeat (33) tick();
    chk("multu_hi", out_hi, 32'hFFFF_FFFE);
    chk("multu_lo", out_lo, 32'h0000_0001);

    // Back-to-back start plus halt
    start_md(3'b001, 32'd3, 32'd5);
    in_md_op = 3'b001; in_rs_data = 32'h0001_2345; in_rt_data = 32'hFFFF_6789;
    #1 count_stalls(n, bad);
    chk("b2b_stall_cycles", n, 33);
    chk("b2b_bubbles", bad, 0);
    tick();
    chk("b2b_first_lo", out_lo, 32'd15);
    clear_inputs();
    in_halt_flag = 1'b1;
    #1 chk("halt_nostall", out_stall, 0);
    tick();
    chk("halt_flag", out_halt_flag_m, 1);
    clear_inputs();
    repeat (33) tick();
    chk("b2b_second", {out_hi, out_lo}, ref_md(3'b001, 32'h0001_2345, 32'hFFFF_6789));

    // Reset mid-operation at RUN count 10
    clear_inputs();
    in_md_op = 3'b011; in_rs_data = 32'd1000; in_rt_data = 32'd7;
    in_alu_result = 32'h55; in_writeBack_bus = 2'b11; in_write_reg = 5'd7;
    in_memory_bus = 9'h1FF; in_halt_flag = 1'b1;
    tick();
    clear_inputs();
    repeat (10) tick();
    in_md_op = 3'b101;
    reset = 1'b0;
    #1;
    chk("rst_addr", out_addr_mem, 0);
    chk("rst_hi", out_hi, 0);
    chk("rst_lo", out_lo, 0);
    chk("rst_stall", out_stall, 0);
    #2 reset = 1'b1;
    #1 chk("rst_mfhi_nostall", out_stall, 0);
    tick();
    chk("rst_mfhi_val", out_addr_mem, 0);
    repeat (40) tick();
    chk("rst_no_late_write", {out_hi, out_lo}, 0);
    clear_inputs();

    // Randomized mult/div against the reference
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(1, 4));
      rs = $urandom();
      rt = $urandom();
      case ($urandom_range(0, 7))
        0: rt = 32'h0;
        1: begin rs = 32'h8000_0000; rt = 32'hFFFF_FFFF; end
        2: rt = 32'($urandom_range(1, 9));
        default: ;
      endcase
      start_md(op, rs, rt);
      repeat (34) tick();
      chk($sformatf("rnd%0d_op%0d_%h_%h", i, op, rs, rt), {out_hi, out_lo}, ref_md(op, rs, rt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
